// File: rtl/dma_desc_queue.sv
// Descriptor FIFO + launcher feeding dma_controller; counts completions, raises sticky irq/err. Optional macro: DMA_DESC_TIMEOUT_EN.
// Latency: push at t0 -> pop at t1 -> start_transfer high t2..t3; completion seen at tn -> done_pulse tn..tn+1, next pop tn+1.
// Backpressure: desc_ready is a registered !full; a pop while full re-opens desc_ready only on the following cycle.
module dma_desc_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [31:0]              desc_src,
  input  logic [31:0]              desc_dest,
  input  logic [31:0]              desc_len,
  output logic                     start_transfer,
  output logic [31:0]              src_addr,
  output logic [31:0]              dest_addr,
  output logic [31:0]              transfer_length,
  input  logic                     dma_busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     done_pulse,
  output logic [15:0]              done_count,
  output logic                     irq,
  input  logic                     irq_clear,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dest;
    logic [31:0] len;
  } desc_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  desc_t          mem_q [DEPTH];
  desc_t          mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic           start_q, start_d;
  desc_t          cur_q, cur_d;
  logic           done_q, done_d;
  logic [15:0]    dcnt_q, dcnt_d;
  logic           irq_q, irq_d;
  logic           err_q, err_d;

  logic push, len_ok, store, pop, completion, tmo_hit;

  // Handshake decode: accepted descriptors with zero or non-word-multiple length are dropped.
  always_comb begin
    push       = desc_valid && ready_q;
    len_ok     = (desc_len != 32'd0) && (desc_len[1:0] == 2'b00);
    store      = push && len_ok;
    pop        = (state_q == IDLE) && (count_q != '0);
    completion = (state_q == WAIT_DONE) && !dma_busy;
  end

`ifdef DMA_DESC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Cycles spent in WAIT_BUSY; restarts from zero on every entry.
  always_comb begin
    tmo_d   = (state_q == WAIT_BUSY) ? tmo_q + TW'(1) : '0;
    tmo_hit = (state_q == WAIT_BUSY) && !dma_busy && (tmo_q == TW'(TIMEOUT - 1));
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo_hit        = 1'b0;
`endif

  // Launch sequencer next state: one descriptor in flight at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (dma_busy)     state_d = WAIT_DONE;
        else if (tmo_hit) state_d = IDLE;
      end
      WAIT_DONE: if (!dma_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping, launch registers and status flags.
  always_comb begin
    mem_d = mem_q;
    if (store) mem_d[wr_ptr_q] = '{src: desc_src, dest: desc_dest, len: desc_len};
    wr_ptr_d = wr_ptr_q + AW'(store);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(store) - CW'(pop);
    ready_d  = (count_d != CW'(DEPTH));
    cur_d    = pop ? mem_q[rd_ptr_q] : cur_q;
    start_d  = (state_q == LAUNCH);
    done_d   = completion;
    dcnt_d   = dcnt_q + 16'(completion);
    if (completion)     irq_d = 1'b1;
    else if (irq_clear) irq_d = 1'b0;
    else                irq_d = irq_q;
    err_d = err_q | (push && !len_ok) | tmo_hit;
  end

  // State registers; reset abandons any queued or in-flight descriptor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      start_q  <= 1'b0;
      cur_q    <= '0;
      done_q   <= 1'b0;
      dcnt_q   <= '0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      cur_q    <= cur_d;
      done_q   <= done_d;
      dcnt_q   <= dcnt_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
    end
  end

  assign desc_ready      = ready_q;
  assign start_transfer  = start_q;
  assign src_addr        = cur_q.src;
  assign dest_addr       = cur_q.dest;
  assign transfer_length = cur_q.len;
  assign queue_count     = count_q;
  assign done_pulse      = done_q;
  assign done_count      = dcnt_q;
  assign irq             = irq_q;
  assign err             = err_q;

endmodule

// File: tb/tb_dma_desc_queue.sv
module tb_dma_desc_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          desc_valid, desc_ready;
  logic [31:0]   desc_src, desc_dest, desc_len;
  logic          start_transfer;
  logic [31:0]   src_addr, dest_addr, transfer_length;
  logic          dma_busy;
  logic [CW-1:0] queue_count;
  logic          done_pulse;
  logic [15:0]   done_count;
  logic          irq, irq_clear, err;

  always #5 clk = ~clk;

  dma_desc_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dest(desc_dest), .desc_len(desc_len),
    .start_transfer(start_transfer), .src_addr(src_addr), .dest_addr(dest_addr),
    .transfer_length(transfer_length), .dma_busy(dma_busy),
    .queue_count(queue_count), .done_pulse(done_pulse), .done_count(done_count),
    .irq(irq), .irq_clear(irq_clear), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {logic [31:0] s; logic [31:0] d; logic [31:0] l;} d_t;
  d_t          mq[$];
  int          cyc, pop_cyc;
  bit          act, seen_busy;
  logic        e_ready, e_start, e_done, e_irq, e_err;
  logic [31:0] e_src, e_dest, e_len;
  logic [15:0] e_dc;

  task automatic model_reset();
    mq.delete();
    cyc = 0; pop_cyc = 0; act = 0; seen_busy = 0;
    e_ready = 1; e_start = 0; e_done = 0; e_irq = 0; e_err = 0;
    e_src = 0; e_dest = 0; e_len = 0; e_dc = 0;
  endtask

  // One rising edge: a popped descriptor launches on the next edge, then busy is
  // watched from the edge after that; completion is the first idle busy after a busy one.
  task automatic model_step();
    bit done, abort, ready_pre;
    d_t h;
    cyc++;
    done = 0; abort = 0;
    e_start = 0;
    if (act) begin
      if (cyc == pop_cyc + 1) e_start = 1;
      else if (!seen_busy) begin
        if (dma_busy) seen_busy = 1;
`ifdef DMA_DESC_TIMEOUT_EN
        else if (cyc - (pop_cyc + 1) == TIMEOUT) abort = 1;
`endif
      end else if (!dma_busy) done = 1;
    end
    ready_pre = (mq.size() < DEPTH);
    if (!act && mq.size() > 0) begin
      h = mq.pop_front();
      e_src = h.s; e_dest = h.d; e_len = h.l;
      act = 1; pop_cyc = cyc; seen_busy = 0;
    end
    if (done || abort) act = 0;
    if (desc_valid && ready_pre) begin
      if (desc_len != 0 && desc_len % 4 == 0) mq.push_back('{desc_src, desc_dest, desc_len});
      else e_err = 1;
    end
    if (abort) e_err = 1;
    e_done = done;
    if (done) e_dc = e_dc + 16'd1;
    e_irq = done ? 1'b1 : (irq_clear ? 1'b0 : e_irq);
    e_ready = (mq.size() < DEPTH);
  endtask

  task automatic compare_all();
    chk("desc_ready", desc_ready, e_ready);
    chk("start_transfer", start_transfer, e_start);
    chk("src_addr", src_addr, e_src);
    chk("dest_addr", dest_addr, e_dest);
    chk("transfer_length", transfer_length, e_len);
    chk("queue_count", queue_count, mq.size());
    chk("done_pulse", done_pulse, e_done);
    chk("done_count", done_count, e_dc);
    chk("irq", irq, e_irq);
    chk("err", err, e_err);
  endtask

  // ---------------- dma_controller busy responder ----------------
  int nneg = 0, b_on = -1, b_off = -1;
  bit mode_hold = 0, mode_never = 0, r_rand = 0;
  int r_dly = 0, r_len = 16;
  int starts = 0, dones = 0;
  logic [31:0] cap_src, cap_dest, cap_len;

  task automatic respond();
    int dly, len;
    if (start_transfer) begin
      dly   = r_rand ? int'($urandom_range(0, 2)) : r_dly;
      len   = r_rand ? int'($urandom_range(1, 12)) : r_len;
      b_on  = nneg + 1 + dly;
      b_off = b_on + len;
    end
    dma_busy = mode_hold ? 1'b1 : (mode_never ? 1'b0 : (nneg >= b_on && nneg < b_off));
  endtask

  task automatic cyc1();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    nneg++;
    compare_all();
    if (start_transfer) begin
      starts++; cap_src = src_addr; cap_dest = dest_addr; cap_len = transfer_length;
    end
    if (done_pulse) dones++;
    respond();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc1();
  endtask

  task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input int bound, output bit acc);
    acc = 0;
    desc_valid = 1; desc_src = s; desc_dest = d; desc_len = l;
    for (int i = 0; i < bound; i++) begin
      bit r;
      r = desc_ready;
      cyc1();
      if (r) begin acc = 1; break; end
    end
    desc_valid = 0;
  endtask

  task automatic do_async_reset();
    #2 reset = 1;
    #1;
    chk("arst_ready", desc_ready, 1);
    chk("arst_start", start_transfer, 0);
    chk("arst_src", src_addr, 0);
    chk("arst_dest", dest_addr, 0);
    chk("arst_len", transfer_length, 0);
    chk("arst_qc", queue_count, 0);
    chk("arst_done", done_pulse, 0);
    chk("arst_dc", done_count, 0);
    chk("arst_irq", irq, 0);
    chk("arst_err", err, 0);
    model_reset();
    mode_hold = 0; mode_never = 0; b_on = -1; b_off = -1;
    desc_valid = 0; irq_clear = 0; dma_busy = 0;
    @(posedge clk);
    @(negedge clk);
    nneg++;
    reset = 0;
    starts = 0; dones = 0;
  endtask

  initial begin
    bit acc, got;
    reset = 1; desc_valid = 0; desc_src = 0; desc_dest = 0; desc_len = 0;
    dma_busy = 0; irq_clear = 0;
    model_reset();
    @(negedge clk);
    nneg++;
    chk("rst_ready", desc_ready, 1);
    chk("rst_qc", queue_count, 0);
    chk("rst_dc", done_count, 0);
    compare_all();
    reset = 0;

    // Single transfer with busy raised 1 cycle after the launch, held 16 cycles.
    r_rand = 0; r_dly = 0; r_len = 16;
    push_desc(32'h0, 32'h1000, 32'h40, 3, acc);
    chk("single_acc", acc, 1);
    chk("t0_qc", queue_count, 1);
    cyc1();
    chk("t1_qc", queue_count, 0);
    chk("t1_start", start_transfer, 0);
    cyc1();
    chk("t2_start", start_transfer, 1);
    run(40);
    chk("single_starts", starts, 1);
    chk("single_src", cap_src, 32'h0);
    chk("single_dest", cap_dest, 32'h1000);
    chk("single_len", cap_len, 32'h40);
    chk("single_dones", dones, 1);
    chk("single_dc", done_count, 1);
    chk("single_irq", irq, 1);

    // Completion coinciding with irq_clear: set wins, then clear takes effect.
    r_len = 6;
    irq_clear = 1;
    push_desc(32'h100, 32'h2000, 32'h80, 3, acc);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      cyc1();
      if (done_pulse) begin
        chk("irq_set_wins", irq, 1);
        cyc1();
        chk("irq_clear_next", irq, 0);
        got = 1;
        break;
      end
    end
    chk("coinc_done_seen", got, 1);
    irq_clear = 0;

    // Bad lengths are consumed and dropped.
    do_async_reset();
    push_desc(32'h10, 32'h20, 32'h0, 3, acc);
    push_desc(32'h10, 32'h20, 32'h41, 3, acc);
    run(10);
    chk("bad_err", err, 1);
    chk("bad_qc", queue_count, 0);
    chk("bad_starts", starts, 0);

    // Fill with busy stuck high.
    do_async_reset();
    mode_hold = 1; r_len = 4;
    for (int k = 0; k < 5; k++) begin
      push_desc(32'h1000 * k, 32'h8000 + k, 32'h4 * (k + 1), 5, acc);
      chk("fill_acc", acc, 1);
    end
    run(2);
    chk("fill_qc", queue_count, 4);
    chk("fill_ready", desc_ready, 0);
    chk("fill_starts", starts, 1);
    push_desc(32'h6000, 32'h6666, 32'h18, 10, acc);
    chk("fill_6th_pending", acc, 0);
    mode_hold = 0;
    push_desc(32'h6000, 32'h6666, 32'h18, 60, acc);
    chk("fill_6th_accept", acc, 1);
    run(150);
    chk("fill_dc", done_count, 6);

    // Busy never rises.
    do_async_reset();
    mode_never = 1;
    push_desc(32'h1, 32'h2, 32'h4, 3, acc);
    push_desc(32'h3, 32'h4, 32'h8, 3, acc);
    run(40);
`ifdef DMA_DESC_TIMEOUT_EN
    chk("tmo_err", err, 1);
    chk("tmo_dc", done_count, 0);
    chk("tmo_starts", starts, 2);
`else
    chk("stuck_starts", starts, 1);
    chk("stuck_dc", done_count, 0);
    chk("stuck_qc", queue_count, 1);
    chk("stuck_err", err, 0);
`endif

    // Reset while waiting for completion with two descriptors queued.
    do_async_reset();
    mode_hold = 1;
    for (int k = 0; k < 3; k++) push_desc(32'h40 * k, 32'h400 + k, 32'h10, 5, acc);
    run(4);
    chk("wd_qc", queue_count, 2);
    chk("wd_starts", starts, 1);
    do_async_reset();
    run(3);

    // Randomized traffic.
    r_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_async_reset();
      desc_valid = $urandom_range(0, 1) == 1;
      desc_src   = $urandom;
      desc_dest  = $urandom;
      if ($urandom_range(0, 9) == 0)
        desc_len = ($urandom_range(0, 1) == 1) ? 32'h0 : ((32'($urandom_range(1, 64)) << 2) | 32'($urandom_range(1, 3)));
      else
        desc_len = 32'($urandom_range(1, 64)) << 2;
      irq_clear = $urandom_range(0, 9) == 0;
      cyc1();
    end
    desc_valid = 0; irq_clear = 0;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_desc_queue.md
# dma_desc_queue

Descriptor queue and launcher placed directly upstream of `dma_controller`. Software or a host master pushes transfer descriptors into a small FIFO. The block issues them one at a time on the `start_transfer`/`src_addr`/`dest_addr`/`transfer_length` inputs of `dma_controller` and tracks each transfer's completion through `dma_busy`. On every completion it raises a sticky interrupt and increments a completion counter.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two, minimum 2.
- `TIMEOUT`, default 16: cycles to wait for `dma_busy` to rise after a launch (used only with `DMA_DESC_TIMEOUT_EN`).
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `desc_valid`  in  1: a descriptor is presented.
- `desc_ready`  out  1: the FIFO can accept a descriptor; equals `!full`.
- `desc_src`  in  32: descriptor source address.
- `desc_dest`  in  32: descriptor destination address.
- `desc_len`  in  32: descriptor length in bytes.
- `start_transfer`  out  1: one-cycle launch pulse to `dma_controller`.
- `src_addr`, `dest_addr`, `transfer_length`  out  32 each: registered copy of the descriptor currently launched.
- `dma_busy`  in  1: busy flag from `dma_controller`.
- `queue_count`  out  $clog2(DEPTH)+1: number of FIFO entries.
- `done_pulse`  out  1: one-cycle pulse per completed transfer.
- `done_count`  out  16: completed transfers; wraps 0xFFFF→0x0000.
- `irq`  out  1: sticky completion interrupt.
- `irq_clear`  in  1: clears `irq`.
- `err`  out  1: sticky error flag; cleared only by reset.

## Operation
- **Enqueue:** a push happens on an edge where `desc_valid && desc_ready`.
  - A descriptor with `desc_len == 0` or `desc_len[1:0] != 0` is consumed but dropped: it is not stored and `err` is set.
- **FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if the FIFO is non-empty, pop the head, load `src_addr`/`dest_addr`/`transfer_length`, and go to LAUNCH.
  - LAUNCH: `start_transfer`=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: when `dma_busy`=1 is sampled, go to WAIT_DONE.
  - WAIT_DONE: when `dma_busy`=0 is sampled, go to IDLE; `done_pulse`=1 for one cycle, `done_count`+1, `irq` set.
- `src_addr`/`dest_addr`/`transfer_length` hold their last launched values until the next pop.
- **`irq`:** set on completion, cleared by `irq_clear`; when both happen in the same cycle, the set wins.
- **Full FIFO:** `desc_ready`=0. A pop in the same cycle does not re-open `desc_ready` until the next cycle.
- **Simultaneous push and pop (FIFO not full):** both occur; `queue_count` is unchanged.
- **Empty FIFO in IDLE:** the FSM stays in IDLE; no pulses are issued.
- **Reset mid-operation:** the FIFO is emptied, the FSM returns to IDLE, and any in-flight descriptor is abandoned (`dma_controller` shares `reset`).

## Timing
- **Reset values:** `desc_ready`=1; `start_transfer`=0; `src_addr`/`dest_addr`/`transfer_length`=0; `queue_count`=0; `done_pulse`=0; `done_count`=0; `irq`=0; `err`=0.
- All outputs are registered.
- **Push into an empty FIFO while IDLE, at edge t0:**
  - `queue_count`=1 after t0.
  - Pop at t1; `queue_count`=0 after t1.
  - `start_transfer`=1 from t2 to t3.
- **Completion:** `dma_busy`=0 sampled at edge tn while in WAIT_DONE → `done_pulse` high from tn to tn+1.
  - The earliest next pop is at tn+1.
  - Minimum spacing between launches is 4 cycles.

## Configuration
- `DMA_DESC_TIMEOUT_EN` defined:
  - WAIT_BUSY counts cycles.
  - If `dma_busy` has not risen after `TIMEOUT` cycles, set `err` and return to IDLE with no `done_pulse`, no `done_count` increment and no `irq`.
- Not defined: WAIT_BUSY waits indefinitely; no counter logic is built.

## Test plan
- **Single transfer:** push src=0x0000_0000, dest=0x0000_1000, len=0x40; model raises `dma_busy` 1 cycle after `start_transfer` and holds it 16 cycles.
  - Exactly one `start_transfer` pulse, with outputs 0x0/0x1000/0x40.
  - One `done_pulse`; `done_count`=1; `irq`=1.
- **Fill:** `dma_busy` held high, DEPTH=4, push 6 descriptors.
  - The first launches.
  - `queue_count` reaches 4 and `desc_ready`=0.
  - The 6th descriptor stays pending until a completion.
- **Bad lengths:** push len=0 then len=0x41.
  - Both dropped; `queue_count` stays 0; `err`=1; no `start_transfer`.
- **Timeout (macro on, TIMEOUT=16):** `dma_busy` never rises.
  - Returns to IDLE 16 cycles after WAIT_BUSY entry; `err`=1; `done_count`=0.
  - With the macro off, the FSM stays in WAIT_BUSY.
- **Reset in WAIT_DONE with 2 entries queued:** assert `reset` asynchronously.
  - All outputs take their reset values immediately; `queue_count`=0.
- **Completion coincident with `irq_clear`:** `irq` remains 1.
  - `irq_clear` on the next cycle drops it to 0.
